// File: rtl/sn_pkg.sv
// Shared types and limits for the stochastic-number stream decoder.
package sn_pkg;
  typedef enum logic [0:0] {
    SN_IDLE  = 1'b0,
    SN_ACCUM = 1'b1
  } sn_state_e;

  localparam int SN_WIN_LOG2_MIN = 8;
  localparam int SN_WIN_LOG2_MAX = 12;
  localparam int SN_PROB_W       = 8;
endpackage

// File: rtl/sn_stream_decoder_if.sv
// Control, SN input stream and result bundle of the stream decoder.
interface sn_stream_decoder_if
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 8
);
  logic                       start;
  logic                       abort;
  logic                       continuous;
  logic                       sn_bit;
  logic                       sn_valid;
  logic                       busy;
  logic                       result_valid;
  logic        [WIN_LOG2:0]   ones_count;
  logic        [SN_PROB_W-1:0] prob_u8;
  logic signed [WIN_LOG2+1:0] bipolar;

  modport master (
    output start, abort, continuous, sn_bit, sn_valid,
    input  busy, result_valid, ones_count, prob_u8, bipolar
  );

  modport slave (
    input  start, abort, continuous, sn_bit, sn_valid,
    output busy, result_valid, ones_count, prob_u8, bipolar
  );
endinterface

// File: rtl/sn_window_counter.sv
// Window bit counter and ones accumulator; self-clears on the final bit of a window.
module sn_window_counter #(
  parameter int WIN_LOG2 = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              valid,
  input  logic              sn_bit,
  output logic              last_bit,
  output logic [WIN_LOG2:0] ones_next
);
  logic [WIN_LOG2-1:0] bit_cnt;
  logic [WIN_LOG2:0]   ones_acc;

  assign ones_next = ones_acc + {{WIN_LOG2{1'b0}}, sn_bit};
  assign last_bit  = valid && (bit_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      ones_acc <= '0;
    end else if (clear || last_bit) begin
      bit_cnt  <= '0;
      ones_acc <= '0;
    end else if (valid) begin
      bit_cnt  <= bit_cnt + WIN_LOG2'(1);
      ones_acc <= ones_next;
    end
  end
endmodule

// File: rtl/sn_stream_decoder.sv
// Windowed stochastic-to-binary decoder: counts ones over 2^WIN_LOG2 valid bits.
//   state | meaning
//   IDLE  | waiting for start; counters held clear, sn_valid ignored
//   ACCUM | counting valid bits; result published on the final bit
module sn_stream_decoder
  import sn_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input logic                clk,
  input logic                rst_n,
  sn_stream_decoder_if.slave bus
);
  localparam logic [0:0] IDLE  = SN_IDLE;
  localparam logic [0:0] ACCUM = SN_ACCUM;
  localparam logic [WIN_LOG2+1:0] WIN_LEN = {2'b01, {WIN_LOG2{1'b0}}};

  if (WIN_LOG2 < SN_WIN_LOG2_MIN || WIN_LOG2 > SN_WIN_LOG2_MAX) begin : g_bad_win
    $error("sn_stream_decoder: WIN_LOG2 must be within 8..12");
  end

  logic [0:0]              state;
  logic [0:0]              state_nx;
  logic                    in_accum;
  logic                    last_bit;
  logic                    done;
  logic [WIN_LOG2:0]       ones_next;
  logic [WIN_LOG2-1:0]     prob_sat;
  logic [SN_PROB_W-1:0]    prob_nx;
  logic [WIN_LOG2+1:0]     bipolar_nx;

  logic                    result_valid_r;
  logic [WIN_LOG2:0]       ones_count_r;
  logic [SN_PROB_W-1:0]    prob_u8_r;
  logic [WIN_LOG2+1:0]     bipolar_r;

  assign in_accum = (state == ACCUM);
  assign done     = in_accum && last_bit && !bus.abort;

  sn_window_counter #(.WIN_LOG2(WIN_LOG2)) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (!in_accum || bus.abort),
    .valid     (in_accum && bus.sn_valid),
    .sn_bit    (bus.sn_bit),
    .last_bit  (last_bit),
    .ones_next (ones_next)
  );

  always_comb begin
    state_nx = state;
    if (state == IDLE) begin
      if (bus.start && !bus.abort) state_nx = ACCUM;
    end else begin
      if (bus.abort) state_nx = IDLE;
      else if (last_bit && !bus.continuous) state_nx = IDLE;
    end
  end

  // Only an all-ones window reaches 2^WIN_LOG2; clamp it so the top byte saturates at 255.
  assign prob_sat   = ones_next[WIN_LOG2] ? '1 : ones_next[WIN_LOG2-1:0];
  assign prob_nx    = prob_sat[WIN_LOG2-1 -: SN_PROB_W];
  assign bipolar_nx = {ones_next, 1'b0} - WIN_LEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      result_valid_r <= 1'b0;
      ones_count_r   <= '0;
      prob_u8_r      <= '0;
      bipolar_r      <= '0;
    end else begin
      state          <= state_nx;
      result_valid_r <= done;
      if (done) begin
        ones_count_r <= ones_next;
        prob_u8_r    <= prob_nx;
        bipolar_r    <= bipolar_nx;
      end
    end
  end

  assign bus.busy         = in_accum;
  assign bus.result_valid = result_valid_r;
  assign bus.ones_count   = ones_count_r;
  assign bus.prob_u8      = prob_u8_r;
  assign bus.bipolar      = bipolar_r;
endmodule

// File: tb/tb_sn_stream_decoder.sv
// Directed and random stimulus for sn_stream_decoder against a window-level reference model.
module tb_sn_stream_decoder;
  localparam int W = 8;
  localparam int N = 1 << W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sn_stream_decoder_if #(.WIN_LOG2(W)) bus ();
  sn_stream_decoder #(.WIN_LOG2(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  string phase = "reset";

  // Reference model: collect the valid bits of the open window, sum them when it fills.
  bit    m_active = 1'b0;
  int    win_q[$];
  int    e_ones = 0;
  int    e_prob = 0;
  int    e_bip  = 0;
  bit    e_rv   = 1'b0;
  int    rv_seen = 0;

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  function automatic void model_close_window();
    int ones = 0;
    foreach (win_q[i]) ones += win_q[i];
    e_ones = ones;
    e_prob = ((ones > N - 1) ? N - 1 : ones) >> (W - 8);
    e_bip  = 2 * ones - N;
    e_rv   = 1'b1;
    win_q.delete();
  endfunction

  task automatic check_outputs();
    chk("result_valid", bus.result_valid, e_rv);
    chk("busy",         bus.busy,         m_active);
    chk("ones_count",   bus.ones_count,   e_ones);
    chk("prob_u8",      bus.prob_u8,      e_prob);
    chk("bipolar",      bus.bipolar,      e_bip);
  endtask

  task automatic cyc(bit st, bit ab, bit ct, bit b, bit v);
    bus.start      = st;
    bus.abort      = ab;
    bus.continuous = ct;
    bus.sn_bit     = b;
    bus.sn_valid   = v;
    @(posedge clk);
    #1;
    e_rv = 1'b0;
    if (!m_active) begin
      if (st && !ab) begin
        m_active = 1'b1;
        win_q.delete();
      end
    end else if (ab) begin
      m_active = 1'b0;
      win_q.delete();
    end else if (v) begin
      win_q.push_back(int'(b));
      if (win_q.size() == N) begin
        model_close_window();
        m_active = ct;
      end
    end
    if (e_rv) rv_seen++;
    check_outputs();
  endtask

  task automatic expect_result(int ones, int prob, int bip);
    chk("spec_ones", bus.ones_count, ones);
    chk("spec_prob", bus.prob_u8,    prob);
    chk("spec_bip",  bus.bipolar,    bip);
  endtask

  initial begin
    int rv_before;
    bus.start = 1'b0; bus.abort = 1'b0; bus.continuous = 1'b0;
    bus.sn_bit = 1'b0; bus.sn_valid = 1'b0;

    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    phase = "all_ones";
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 1, 1);
    chk("pulse", bus.result_valid, 1'b1);
    expect_result(256, 255, 256);
    cyc(0, 0, 0, 0, 0);
    chk("busy_after", bus.busy, 1'b0);

    phase = "alternating";
    cyc(1, 0, 0, 1, 1);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, (i % 2) == 0, 1);
    expect_result(128, 128, 0);

    phase = "sparse_zero";
    cyc(1, 0, 0, 0, 0);
    rv_before = rv_seen;
    for (int i = 0; i < 2 * N; i++) cyc(0, 0, 0, 0, (i % 2) == 0);
    chk("pulse_count", rv_seen - rv_before, 1);
    expect_result(0, 0, -256);

    phase = "continuous";
    cyc(1, 0, 1, 0, 0);
    rv_before = rv_seen;
    for (int i = 0; i < N; i++) cyc(0, 0, 1, i < 64, 1);
    chk("pulse_a", bus.result_valid, 1'b1);
    expect_result(64, 64, -128);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, i < 192, 1);
    chk("pulse_b", bus.result_valid, 1'b1);
    expect_result(192, 192, 128);
    chk("pulse_count", rv_seen - rv_before, 2);
    cyc(0, 0, 0, 1, 1);
    chk("busy_after", bus.busy, 1'b0);

    phase = "abort";
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(i == 50, 0, 0, 1, 1);
    cyc(0, 1, 0, 1, 1);
    chk("busy_after_abort", bus.busy, 1'b0);
    expect_result(192, 192, 128);
    cyc(1, 1, 0, 1, 1);
    chk("abort_beats_start", bus.busy, 1'b0);
    cyc(1, 0, 0, 0, 0);
    rv_before = rv_seen;
    for (int i = 0; i < N; i++) cyc(($urandom_range(0, 15) == 0), 0, 0, $urandom_range(0, 1), 1);
    chk("window_len", rv_seen - rv_before, 1);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 1, 1, 1);
    cyc(0, 1, 1, 1, 1);
    chk("final_abort_no_pulse", bus.result_valid, 1'b0);
    chk("final_abort_idle", bus.busy, 1'b0);

    phase = "async_reset";
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++) cyc(0, 0, 0, $urandom_range(0, 1), 1);
    bus.sn_valid = 1'b0; bus.sn_bit = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_active = 1'b0; win_q.delete();
    e_rv = 1'b0; e_ones = 0; e_prob = 0; e_bip = 0;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(0, 0, 0, $urandom_range(0, 3) != 0, 1);
    chk("fresh_pulse", bus.result_valid, 1'b1);

    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      bit st, ab, ct, b, v;
      st = m_active ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 599) == 0);
      ct = $urandom_range(0, 1);
      b  = ($urandom_range(0, 7) < (i / 500));
      v  = ($urandom_range(0, 3) != 0);
      cyc(st, ab, ct, b, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
